if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- PC_STEP, 4, sequential PC increment.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock; all state updates on posedge.
- rst, in, 1, reset: synchronous, active-low.
- pc_write_n, in, 1, 1 = hold PC (stall); 0 = advance. Same polarity as the IF/ID write control.
- branch_taken, in, 1, redirect request from ID.
- branch_target, in, 32, redirect address.
- imem_req, out, 1, instruction memory request valid.
- imem_addr, out, 32, request address.
- imem_ready, in, 1, memory accepts the request and returns data this cycle.
- imem_rdata, in, 32, instruction word, valid when imem_ready=1.
- pc_out, out, 32, PC+PC_STEP of the fetched instruction; feeds the IF/ID PC input.
- inst_out, out, 32, fetched instruction, or 32'h0 (NOP) when no valid fetch.
- if_flush, out, 1, pulse to squash the IF/ID instruction on redirect.
- fetch_busy, out, 1, request outstanding and imem_ready=0.

Function
REQ-003 FSM SHALL have three states: IDLE, REQ, DROP.
REQ-004 IDLE SHALL drive imem_req=0 and go to REQ on the next cycle unconditionally.
REQ-005 REQ and DROP SHALL drive imem_req=1 and imem_addr=req_addr. req_addr is a register that stays stable until imem_ready=1.
REQ-006 In REQ, req_addr SHALL equal pc.
REQ-007 In REQ with imem_ready=1 and branch_taken=0:
- inst_out=imem_rdata and pc_out=req_addr+PC_STEP, combinationally, in the same cycle.
- If pc_write_n=0: pc and req_addr SHALL load pc+PC_STEP.
- If pc_write_n=1: pc SHALL hold, and the same address is refetched next cycle.
REQ-008 In any state other than REQ with imem_ready=1, inst_out SHALL be 32'h0 and pc_out SHALL equal pc+PC_STEP.
REQ-009 branch_taken=1 in REQ or DROP SHALL:
- load pc with {branch_target[31:2],2'b00};
- assert if_flush=1 for that cycle;
- force inst_out=0.
branch_taken SHALL take priority over pc_write_n.
REQ-010 Branch in REQ with imem_ready=1: req_addr SHALL load the target and the FSM SHALL stay in REQ.
REQ-011 Branch in REQ with imem_ready=0: the FSM SHALL go to DROP with req_addr unchanged.
REQ-012 In DROP with imem_ready=1: returned data SHALL be discarded, req_addr SHALL load pc, and the FSM SHALL go to REQ.
REQ-013 A further branch while in DROP SHALL overwrite pc with the newest target and the FSM SHALL stay in DROP.
REQ-014 branch_taken in IDLE SHALL load pc; if_flush SHALL stay 0 in IDLE.
REQ-015 PC arithmetic SHALL be 32-bit modulo 2^32: pc 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-016 fetch_busy SHALL equal imem_req & ~imem_ready.

Reset
REQ-017 While rst=0 at posedge, the block SHALL load: pc=RESET_PC, req_addr=RESET_PC, state=IDLE.
REQ-018 During and after reset until leaving IDLE, outputs SHALL be: imem_req=0, if_flush=0, inst_out=0.
REQ-019 Reset asserted mid-request SHALL abandon the outstanding request with no DROP, and imem_req SHALL be 0 the next cycle.

Structure
REQ-020 A shared pipeline package SHALL hold: the FSM state encoding, the NOP constant 32'h0, and the RESET_PC default.
REQ-021 The PC register and next-PC mux SHALL be a sub-module named pc_reg. The FSM, req_addr and output muxing SHALL stay in if_stage.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then imem_ready tied 1, rdata=addr: imem_addr 0 (IDLE one cycle), then 0,4,8; pc_out 4,8,12; if_flush never set.
- pc_write_n=1 for 2 cycles at pc=8: imem_addr stays 8 for 3 cycles, inst_out repeats, pc then advances to 12.
- imem_ready=0 for 3 cycles at pc=4: imem_addr held at 4, fetch_busy=1, inst_out=0; on ready inst_out=rdata, pc_out=8.
- Branch to 32'h100 while pc=8, ready=0: if_flush 1 for one cycle, DROP; ready returns data that is discarded (inst_out=0); next imem_addr=32'h100.
- Branch to 32'h103 together with pc_write_n=1: pc becomes 32'h100 and the branch wins over the stall.
- pc=32'hFFFF_FFFC with ready=1: next imem_addr=0; rst=0 mid-wait: imem_req=0 next cycle, pc=RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline package for the instruction fetch stage.
// Holds the fetch FSM state encoding, the NOP encoding and the default reset PC.
package if_stage_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } fetch_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register with its next-PC mux.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   redirect        load the word-aligned target (wins over advance)
//   target          redirect address
//   advance         step the PC by PC_STEP
//   pc              current PC
//   pc_next         value the PC takes at the next posedge (reset aside)
//   pc_plus_step    pc + PC_STEP, modulo 2^32
module pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic [31:0] pc_plus_step
);

    logic [31:0] pc_q;
    logic        unused_target_lsbs;

    // Low target bits are dropped: fetch addresses are always word aligned.
    assign unused_target_lsbs = ^target[1:0];

    assign pc_plus_step = pc_q + 32'(PC_STEP);

    always_comb begin
        pc_next = pc_q;
        if (redirect) begin
            pc_next = {target[31:2], 2'b00};
        end else if (advance) begin
            pc_next = pc_plus_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches to instruction memory, handles
// stalls and branch redirects, and squashes responses made stale by a redirect.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   pc_write_n                1 = hold PC (stall), 0 = advance
//   branch_taken/_target      redirect request from ID
//   imem_req/imem_addr        memory request valid / address
//   imem_ready/imem_rdata     memory accept + data (same cycle)
//   pc_out                    PC+PC_STEP of the fetched instruction
//   inst_out                  fetched instruction or NOP
//   if_flush                  squash IF/ID on redirect
//   fetch_busy                request outstanding and not ready
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write_n,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        if_flush,
    output logic        fetch_busy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  pc, pc_next, pc_plus_step;
    logic         in_req, fetch_ok, advance;

    assign in_req   = (state_q == StReq);
    // A response is usable only in REQ, on ready, and without a competing redirect.
    assign fetch_ok = in_req && imem_ready && !branch_taken;
    assign advance  = fetch_ok && !pc_write_n;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .redirect     (branch_taken),
        .target       (branch_target),
        .advance      (advance),
        .pc           (pc),
        .pc_next      (pc_next),
        .pc_plus_step (pc_plus_step)
    );

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            StIdle: begin
                // Track the PC (including a redirect taken here) so REQ starts at pc.
                req_addr_d = pc_next;
                state_d    = StReq;
            end
            StReq: begin
                if (imem_ready) begin
                    req_addr_d = pc_next;
                end else if (branch_taken) begin
                    // Keep the outstanding address stable; its data will be dropped.
                    state_d = StDrop;
                end
            end
            StDrop: begin
                // A branch with ready here still retires the stale request; the
                // newest target is picked up through pc_next.
                if (imem_ready) begin
                    req_addr_d = pc_next;
                    state_d    = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_comb begin
        imem_req   = (state_q != StIdle);
        imem_addr  = req_addr_q;
        inst_out   = fetch_ok ? imem_rdata : NOP;
        pc_out     = (in_req && imem_ready) ? (req_addr_q + 32'(PC_STEP)) : pc_plus_step;
        if_flush   = imem_req && branch_taken;
        fetch_busy = imem_req && !imem_ready;
    end

endmodule
